// File: rtl/morse_pkg.sv
// Shared types and constants for the Morse sequencer slice.
package morse_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    SHIFT = 3'd2,
    FETCH = 3'd3,
    ON    = 3'd4,
    GAP   = 3'd5,
    DONE  = 3'd6
  } morse_st_e;

  localparam int   MAX_SYM  = 4;
  localparam logic SYM_DOT  = 1'b0;
  localparam logic SYM_DASH = 1'b1;

  // Letters longer than MAX_SYM symbols are clipped to MAX_SYM.
  function automatic logic [2:0] clamp_len(input logic [2:0] len);
    return (len > 3'(MAX_SYM)) ? 3'(MAX_SYM) : len;
  endfunction

endpackage

// File: rtl/morse_seq_ctrl_if.sv
// Handshake bundle between the button/letter inputs, data_reg and the sequencer.
interface morse_seq_ctrl_if;
  logic       start_i;
  logic [2:0] len_i;
  logic       data_i;
  logic       load_o;
  logic       shift_o;
  logic       led_o;
  logic       busy_o;
  logic       done_o;

  // Sequencer side.
  modport slave (
    input  start_i, len_i, data_i,
    output load_o, shift_o, led_o, busy_o, done_o
  );

  // Environment side (button logic, data_reg, LED driver).
  modport master (
    output start_i, len_i, data_i,
    input  load_o, shift_o, led_o, busy_o, done_o
  );
endinterface

// File: rtl/morse_tick_timer.sv
// Loadable down-counter with a zero flag; times dot/dash/gap intervals.
module morse_tick_timer #(
  parameter int TMR_W = 3
) (
  input  logic             half_clk,
  input  logic             rst,
  input  logic             i_ld,
  input  logic [TMR_W-1:0] i_ld_val,
  input  logic             i_en,
  output logic             o_zero
);

  logic [TMR_W-1:0] r_cnt;

  // Load has priority over count; the controller reloads before a wrap could occur.
  always_ff @(posedge half_clk or negedge rst) begin
    if (!rst) begin
      r_cnt <= '0;
    end else if (i_ld) begin
      r_cnt <= i_ld_val;
    end else if (i_en) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/morse_seq_ctrl.sv
// Morse letter sequencer: pulses load, shifts once per symbol and times the LED.
module morse_seq_ctrl
  import morse_pkg::*;
#(
  parameter int DOT_TICKS  = 1,
  parameter int DASH_TICKS = 3,
  parameter int GAP_TICKS  = 1,
  parameter int TMR_W      = 3
) (
  input  logic                 half_clk,
  input  logic                 rst,
  morse_seq_ctrl_if.slave      bus
);

  localparam logic [TMR_W-1:0] DOT_RELOAD  = TMR_W'(DOT_TICKS - 1);
  localparam logic [TMR_W-1:0] DASH_RELOAD = TMR_W'(DASH_TICKS - 1);
  localparam logic [TMR_W-1:0] GAP_RELOAD  = TMR_W'(GAP_TICKS - 1);

  morse_st_e        r_state;
  morse_st_e        w_state_next;
  logic             r_start_q;
  logic             r_req;
  logic [2:0]       r_rem;
  logic             r_load, r_shift, r_led, r_busy, r_done;
  logic             w_load_next, w_shift_next, w_led_next, w_busy_next, w_done_next;
  logic             w_tmr_ld, w_tmr_en, w_tmr_zero;
  logic [TMR_W-1:0] w_tmr_ld_val;

  morse_tick_timer #(.TMR_W(TMR_W)) u_timer (
    .half_clk (half_clk),
    .rst      (rst),
    .i_ld     (w_tmr_ld),
    .i_ld_val (w_tmr_ld_val),
    .i_en     (w_tmr_en),
    .o_zero   (w_tmr_zero)
  );

  // Start edge detect; start_q resets high so a button held through reset is ignored.
  always_ff @(posedge half_clk or negedge rst) begin
    if (!rst) begin
      r_start_q <= 1'b1;
      r_req     <= 1'b0;
    end else begin
      r_start_q <= bus.start_i;
      r_req     <= bus.start_i & ~r_start_q;
    end
  end

  // State register.
  always_ff @(posedge half_clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state decode; requests outside IDLE are dropped, unused codes recover to IDLE.
  always_comb begin
    w_state_next = IDLE;
    case (r_state)
      IDLE:    w_state_next = r_req ? LOAD : IDLE;
      LOAD:    w_state_next = (r_rem == 3'd0) ? DONE : SHIFT;
      SHIFT:   w_state_next = FETCH;
      FETCH:   w_state_next = ON;
      ON:      w_state_next = w_tmr_zero ? GAP : ON;
      GAP:     w_state_next = w_tmr_zero ? ((r_rem != 3'd0) ? SHIFT : DONE) : GAP;
      DONE:    w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  // Timer control: symbol length chosen from data_i in FETCH, gap loaded on the last ON tick.
  always_comb begin
    w_tmr_ld     = 1'b0;
    w_tmr_ld_val = '0;
    w_tmr_en     = 1'b0;
    case (r_state)
      FETCH: begin
        w_tmr_ld     = 1'b1;
        w_tmr_ld_val = (bus.data_i == SYM_DASH) ? DASH_RELOAD : DOT_RELOAD;
      end
      ON: begin
        if (w_tmr_zero) begin
          w_tmr_ld     = 1'b1;
          w_tmr_ld_val = GAP_RELOAD;
        end else begin
          w_tmr_en = 1'b1;
        end
      end
      GAP:     w_tmr_en = ~w_tmr_zero;
      default: w_tmr_en = 1'b0;
    endcase
  end

  // Remaining-symbol count: latched on an accepted request, decremented as each bit is fetched.
  always_ff @(posedge half_clk or negedge rst) begin
    if (!rst) begin
      r_rem <= 3'd0;
    end else if (r_state == IDLE && r_req) begin
      r_rem <= clamp_len(bus.len_i);
    end else if (r_state == FETCH) begin
      r_rem <= r_rem - 3'd1;
    end
  end

  // Moore output decode from the next state so the registered outputs line up with the state.
  always_comb begin
    w_load_next  = (w_state_next == LOAD);
    w_shift_next = (w_state_next == SHIFT);
    w_led_next   = (w_state_next == ON);
    w_done_next  = (w_state_next == DONE);
    w_busy_next  = (w_state_next == LOAD) || (w_state_next == SHIFT) ||
                   (w_state_next == FETCH) || (w_state_next == ON) ||
                   (w_state_next == GAP);
  end

  // Output registers; reset clears them immediately, dropping the LED mid-symbol.
  always_ff @(posedge half_clk or negedge rst) begin
    if (!rst) begin
      r_load  <= 1'b0;
      r_shift <= 1'b0;
      r_led   <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_load  <= w_load_next;
      r_shift <= w_shift_next;
      r_led   <= w_led_next;
      r_busy  <= w_busy_next;
      r_done  <= w_done_next;
    end
  end

  assign bus.load_o  = r_load;
  assign bus.shift_o = r_shift;
  assign bus.led_o   = r_led;
  assign bus.busy_o  = r_busy;
  assign bus.done_o  = r_done;

endmodule
